// File: rtl/mux_sel_buf.sv
// Encoded N_IN-way selector feeding a 2-entry valid/ready output buffer.
// Optional MUX_SEL_BUF_ERR_CNT_EN adds an 8-bit saturating illegal-select counter (err_cnt).
module mux_sel_buf #(
  parameter int N_IN = 6,
  parameter int W    = 5,
  parameter int SW   = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_IN*W-1:0] in_data,
  input  logic [SW-1:0]     in_sel,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [W-1:0]      out_data,
  output logic [SW-1:0]     out_sel,
  output logic              out_illegal,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              err_sticky,
`ifdef MUX_SEL_BUF_ERR_CNT_EN
  output logic [7:0]        err_cnt,
`endif
  input  logic              err_clr
);

  if ((2**SW) < N_IN || N_IN < 2 || N_IN > 16) begin : g_param_chk
    $error("mux_sel_buf: need 2 <= N_IN <= 16 and 2**SW >= N_IN");
  end

  typedef struct packed {
    logic [W-1:0]  data;
    logic [SW-1:0] sel;
    logic          ill;
  } ent_t;

  ent_t       r_ent [2];
  logic [1:0] r_cnt;
  logic       r_err;
  logic       w_ill;
  logic       w_push;
  logic       w_pop;
  logic [W-1:0] w_mux;
  ent_t       w_new;

  // Out-of-range selects fall through to the last input.
  always_comb begin
    w_mux = in_data[(N_IN-1)*W +: W];
    for (int k = 0; k < N_IN; k++)
      if (int'(in_sel) == k) w_mux = in_data[k*W +: W];
  end

  assign w_ill  = (int'(in_sel) >= N_IN);
  assign w_new  = '{data: w_mux, sel: in_sel, ill: w_ill};
  assign in_ready  = (r_cnt != 2'd2);
  assign out_valid = (r_cnt != 2'd0);
  assign w_push = in_valid && in_ready;
  assign w_pop  = out_valid && out_ready;

  // Head lives in entry 0; it is left untouched when the last entry pops so outputs hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt    <= 2'd0;
      r_ent[0] <= '0;
      r_ent[1] <= '0;
    end else begin
      r_cnt <= r_cnt + 2'(w_push) - 2'(w_pop);
      case ({w_push, w_pop})
        2'b10: if (r_cnt == 2'd0) r_ent[0] <= w_new; else r_ent[1] <= w_new;
        2'b01: if (r_cnt == 2'd2) r_ent[0] <= r_ent[1];
        2'b11: r_ent[0] <= w_new;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                r_err <= 1'b0;
    else if (w_push && w_ill) r_err <= 1'b1;
    else if (err_clr)         r_err <= 1'b0;
  end

`ifdef MUX_SEL_BUF_ERR_CNT_EN
  logic [7:0] r_ecnt;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                r_ecnt <= 8'd0;
    else if (err_clr)         r_ecnt <= (w_push && w_ill) ? 8'd1 : 8'd0;
    else if (w_push && w_ill && r_ecnt != 8'd255) r_ecnt <= r_ecnt + 8'd1;
  end
  assign err_cnt = r_ecnt;
`endif

  assign out_data    = r_ent[0].data;
  assign out_sel     = r_ent[0].sel;
  assign out_illegal = r_ent[0].ill;
  assign err_sticky  = r_err;

endmodule

// File: tb/tb_mux_sel_buf.sv
// Directed bench for mux_sel_buf (defaults N_IN=6, W=5, SW=3).
module tb_mux_sel_buf;
  logic        clk = 1'b0;
  logic        reset;
  logic [29:0] in_data;
  logic [2:0]  in_sel;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  out_data;
  logic [2:0]  out_sel;
  logic        out_illegal;
  logic        out_valid;
  logic        out_ready;
  logic        err_sticky;
  logic        err_clr;
`ifdef MUX_SEL_BUF_ERR_CNT_EN
  logic [7:0]  err_cnt;
`endif

  int total = 0;
  int bad   = 0;

  mux_sel_buf #(.N_IN(6), .W(5), .SW(3)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_sel(in_sel),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_sel(out_sel), .out_illegal(out_illegal), .out_valid(out_valid),
    .out_ready(out_ready), .err_sticky(err_sticky),
`ifdef MUX_SEL_BUF_ERR_CNT_EN
    .err_cnt(err_cnt),
`endif
    .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_sel = '0; out_ready = 1'b0; err_clr = 1'b0;
    for (int k = 0; k < 6; k++) in_data[k*5 +: 5] = 5'(10 + k);
    #12;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_out_sel", 32'(out_sel), 0);
    chk("rst_out_illegal", 32'(out_illegal), 0);
    chk("rst_err_sticky", 32'(err_sticky), 0);
    reset = 1'b0;
    tick();
    chk("idle_out_valid", 32'(out_valid), 0);

    // sequential sweep with a free-running consumer
    out_ready = 1'b1;
    for (int s = 0; s < 6; s++) begin
      in_sel = 3'(s); in_valid = 1'b1;
      tick();
      chk("sweep_valid", 32'(out_valid), 1);
      chk("sweep_data", 32'(out_data), 32'(10 + s));
      chk("sweep_sel", 32'(out_sel), 32'(s));
      chk("sweep_illegal", 32'(out_illegal), 0);
      chk("sweep_in_ready", 32'(in_ready), 1);
    end
    in_valid = 1'b0;
    tick();
    chk("drain_valid", 32'(out_valid), 0);
    chk("hold_data", 32'(out_data), 15);
    chk("hold_sel", 32'(out_sel), 5);

    // illegal select defaults to last input
    in_data[25 +: 5] = 5'd31;
    in_sel = 3'd7; in_valid = 1'b1;
    tick();
    chk("ill_data", 32'(out_data), 31);
    chk("ill_sel", 32'(out_sel), 7);
    chk("ill_flag", 32'(out_illegal), 1);
    chk("ill_sticky", 32'(err_sticky), 1);
    in_valid = 1'b0;
    tick();
    chk("ill_sticky_hold", 32'(err_sticky), 1);
    err_clr = 1'b1;
    tick();
    chk("clr_sticky", 32'(err_sticky), 0);
    in_sel = 3'd6; in_valid = 1'b1;
    tick();
    chk("setwins_sticky", 32'(err_sticky), 1);
    chk("sel6_data", 32'(out_data), 31);
    in_valid = 1'b0;
    tick();
    chk("clr2_sticky", 32'(err_sticky), 0);
    err_clr = 1'b0;
    in_data[25 +: 5] = 5'd15;

    // backpressure
    out_ready = 1'b0;
    in_sel = 3'd1; in_valid = 1'b1;
    tick();
    chk("bp1_valid", 32'(out_valid), 1);
    chk("bp1_in_ready", 32'(in_ready), 1);
    chk("bp1_data", 32'(out_data), 11);
    in_sel = 3'd2;
    tick();
    chk("bp2_in_ready", 32'(in_ready), 0);
    chk("bp2_head", 32'(out_data), 11);
    in_sel = 3'd7;
    tick();
    chk("bp3_in_ready", 32'(in_ready), 0);
    chk("bp3_head", 32'(out_data), 11);
    chk("bp3_sticky", 32'(err_sticky), 0);
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk("pop1_data", 32'(out_data), 12);
    chk("pop1_sel", 32'(out_sel), 2);
    chk("pop1_in_ready", 32'(in_ready), 1);
    chk("pop1_valid", 32'(out_valid), 1);
    tick();
    chk("pop2_valid", 32'(out_valid), 0);
    chk("pop2_hold", 32'(out_data), 12);

    // simultaneous push/pop at count 1, capture-at-accept, async reset
    in_sel = 3'd0; in_valid = 1'b1;
    tick();
    chk("pp0_data", 32'(out_data), 10);
    in_sel = 3'd3;
    tick();
    chk("pp1_data", 32'(out_data), 13);
    chk("pp1_valid", 32'(out_valid), 1);
    chk("pp1_in_ready", 32'(in_ready), 1);
    out_ready = 1'b0; in_sel = 3'd4;
    tick();
    chk("pp2_in_ready", 32'(in_ready), 0);
    chk("pp2_head", 32'(out_data), 13);
    in_data[20 +: 5] = 5'd0;
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk("capture_data", 32'(out_data), 14);
    chk("capture_sel", 32'(out_sel), 4);
    in_data[20 +: 5] = 5'd14;
    out_ready = 1'b0; in_sel = 3'd5; in_valid = 1'b1;
    tick();
    chk("full_in_ready", 32'(in_ready), 0);
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("arst_valid", 32'(out_valid), 0);
    chk("arst_in_ready", 32'(in_ready), 1);
    chk("arst_data", 32'(out_data), 0);
    #3 reset = 1'b0;
    tick();
    chk("post_rst_valid", 32'(out_valid), 0);

`ifdef MUX_SEL_BUF_ERR_CNT_EN
    out_ready = 1'b1; in_sel = 3'd7; in_valid = 1'b1;
    tick();
    chk("cnt_first", 32'(err_cnt), 1);
    repeat (299) tick();
    chk("cnt_sat", 32'(err_cnt), 255);
    err_clr = 1'b1;
    tick();
    chk("cnt_clr_set", 32'(err_cnt), 1);
    chk("cnt_clr_sticky", 32'(err_sticky), 1);
    in_valid = 1'b0;
    tick();
    chk("cnt_clr", 32'(err_cnt), 0);
    err_clr = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mux_sel_buf.md
Name: mux_sel_buf

Overview:
- Parametrised successor to the fixed 6-way register-destination selector.
- Selects one of N_IN W-bit inputs by an encoded select, then queues the result in a 2-entry output buffer with valid/ready handshakes on both sides.
- Illegal selects are detected and flagged.
- Sits between the control unit and register-file write port / datapath consumers, so selection results survive consumer stalls across multicycle states.

Parameters:
- N_IN, 6, number of selectable inputs (2..16).
- W, 5, data width of each input and of the output.
- SW, 3, select width; the elaborated design must satisfy 2**SW >= N_IN, checked at elaboration.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_data  input  N_IN*W  flattened inputs; input k occupies bits [k*W +: W].
- in_sel  input  SW  encoded select.
- in_valid  input  1  select/data valid.
- in_ready  output  1  buffer can accept; high when count < 2.
- out_data  output  W  head entry data.
- out_sel  output  SW  head entry select, echoed as captured.
- out_illegal  output  1  head entry was captured with an illegal select.
- out_valid  output  1  buffer not empty.
- out_ready  input  1  consumer accepts the head entry.
- err_sticky  output  1  an illegal select has been accepted since reset or since the last clear.
- err_clr  input  1  synchronous clear of err_sticky.

Behaviour:
- Reset: count=0, both entries zeroed.
  - out_valid=0, in_ready=1, out_data=0, out_sel=0, out_illegal=0, err_sticky=0.
  - Reset is asynchronous and may occur mid-transfer. All buffered entries are discarded, and the first cycle after deassert is empty.
- Accept on an edge with in_valid && in_ready.
  - Push {data, sel, illegal}.
  - data = input[in_sel] if in_sel < N_IN, else input[N_IN-1]. This is the default-to-last rule.
  - illegal = (in_sel >= N_IN).
- Pop on an edge with out_valid && out_ready. The head advances.
- Latency: an entry accepted at edge t into an empty buffer appears on out_* with out_valid=1 after edge t (1 cycle).
- Ordering: strict FIFO. Data is captured at accept time; later changes to in_data do not affect stored entries.
- count transitions:
  - push only: +1.
  - pop only: -1.
  - push and pop in the same edge: unchanged, and the head is replaced by the second entry or the new entry as appropriate.
- Full (count=2): in_ready=0 and no push occurs. A pop in that cycle does not allow a same-cycle push; in_ready rises on the following cycle.
- Empty (count=0): out_valid=0 and out_ready is ignored.
  - out_data, out_sel and out_illegal hold their last values. They are 0 after reset.
- in_ready and out_valid are derived only from registered count. There is no combinational path from in_valid or out_ready to any output.
- err_sticky:
  - Set on the edge that accepts an illegal select.
  - Cleared by err_clr.
  - If set and clear occur on the same edge, set wins.
  - An illegal select that is not accepted (in_ready=0) does not set the flag.
- N_IN = 2**SW: illegal selects are impossible, so out_illegal and err_sticky stay 0.

Optional Feature:
- Macro MUX_SEL_BUF_ERR_CNT_EN.
- Defined:
  - Adds output err_cnt [7:0], an 8-bit saturating count of accepted illegal selects.
  - Reset to 0; saturates at 255.
  - err_clr also zeroes it. If clear and an illegal accept occur on the same edge, the result is 1.
- Undefined: the err_cnt port and its logic are absent; all other behaviour is unchanged.

Test Plan:
1. Reset with in_valid=0, defaults N_IN=6, W=5 -> out_valid=0, in_ready=1, out_data=0, err_sticky=0.
2. Sequential sweep: in_data inputs 0..5 = 5'd10..5'd15; sel=0..5 one per cycle; out_ready=1 -> out_data = 10..15, each 1 cycle after accept; out_illegal=0; no stalls.
3. Illegal select: sel=3'd7 with input 5 = 5'd31 -> out_data=31, out_illegal=1, err_sticky=1. Then err_clr=1 with no illegal accept -> err_sticky=0 on the next cycle.
4. Backpressure: out_ready=0, push sel=1 then sel=2 -> in_ready=0 after the second push, a third in_valid is not accepted, and head stays input 1. Release out_ready -> outputs are input 1 then input 2 in order; in_ready returns 1 cycle after the first pop.
5. Simultaneous push/pop at count=1 -> count stays 1 and the FIFO order is preserved. Assert reset asynchronously mid-stream with count=2 -> out_valid drops immediately, in_ready=1.
6. With MUX_SEL_BUF_ERR_CNT_EN defined: 300 consecutive illegal accepts -> err_cnt=255. err_clr asserted together with an illegal accept -> err_cnt=1, err_sticky=1.
